// File: rtl/mac_array_west_feeder_pkg.sv
// Shared encodings for the west-edge feeder of the MAC array:
// instruction codes, mode codes and the sequencer state type.
package mac_array_west_feeder_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/mac_array_west_feeder_row_skew.sv
// One row's delay line: data and instruction travel together through
// depth register stages so row r lags row 0 by r cycles.
module mac_row_skew #(
  parameter int bw    = 4,
  parameter int depth = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] in_data,
  input  logic [1:0]    in_inst,
  output logic [bw-1:0] out_data,
  output logic [1:0]    out_inst
);

  logic [depth-1:0][bw-1:0] data_q, data_d;
  logic [depth-1:0][1:0]    inst_q, inst_d;

  always_comb begin
    data_d    = data_q;
    inst_d    = inst_q;
    data_d[0] = in_data;
    inst_d[0] = in_inst;
    for (int i = 1; i < depth; i++) begin
      data_d[i] = data_q[i-1];
      inst_d[i] = inst_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      inst_q <= '0;
    end else begin
      data_q <= data_d;
      inst_q <= inst_d;
    end
  end

  assign out_data = data_q[depth-1];
  assign out_inst = inst_q[depth-1];

endmodule

// File: rtl/mac_array_west_feeder.sv
// West-edge feeder: accepts row-parallel vectors, sequences a WS load phase
// and an execute phase, and applies the diagonal row skew for the array.
module mac_array_west_feeder
  import mac_array_west_feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              start,
  input  logic [cnt_bw-1:0] exec_len,
  input  logic [row*bw-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [row*bw-1:0] out_w,
  output logic [row*2-1:0]  inst_w,
  output logic              busy,
  output logic              done
);

  localparam int LCNT_W = $clog2(col + 1);
  localparam int DCNT_W = (row > 1) ? $clog2(row) : 1;
  // With a single row there is nothing to drain after the last slot.
  localparam feeder_state_e AFTER_EXEC = (row > 1) ? ST_DRAIN : ST_DONE;

  feeder_state_e     state_q, state_d;
  logic [cnt_bw-1:0] exec_len_q, exec_len_d;
  logic [cnt_bw-1:0] exec_cnt_q, exec_cnt_d;
  logic [LCNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [row*bw-1:0] slot_data_q, slot_data_d;
  logic [1:0]        slot_inst_q, slot_inst_d;

  // Mode only steers the IDLE exit, so it is captured in the next state
  // rather than in a register of its own.
  always_comb begin
    state_d     = state_q;
    exec_len_d  = exec_len_q;
    exec_cnt_d  = exec_cnt_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    slot_data_d = slot_data_q;
    slot_inst_d = INST_IDLE;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exec_len_d  = exec_len;
          exec_cnt_d  = '0;
          load_cnt_d  = '0;
          drain_cnt_d = '0;
          if (mode == MODE_WS)     state_d = ST_LOAD;
          else if (exec_len == '0) state_d = ST_DONE;
          else                     state_d = ST_EXEC;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          slot_data_d = in_data;
          slot_inst_d = INST_LOAD;
          load_cnt_d  = load_cnt_q + LCNT_W'(1);
          if (load_cnt_d == LCNT_W'(col))
            state_d = (exec_len_q == '0) ? AFTER_EXEC : ST_EXEC;
        end
      end
      ST_EXEC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          slot_data_d = in_data;
          slot_inst_d = INST_EXEC;
          exec_cnt_d  = exec_cnt_q + cnt_bw'(1);
          if (exec_cnt_d == exec_len_q) state_d = AFTER_EXEC;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        if (drain_cnt_d == DCNT_W'(row - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      exec_len_q  <= '0;
      exec_cnt_q  <= '0;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      slot_data_q <= '0;
      slot_inst_q <= INST_IDLE;
    end else begin
      state_q     <= state_d;
      exec_len_q  <= exec_len_d;
      exec_cnt_q  <= exec_cnt_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      slot_data_q <= slot_data_d;
      slot_inst_q <= slot_inst_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  assign out_w[0 +: bw] = slot_data_q[0 +: bw];
  assign inst_w[1:0]    = slot_inst_q;

  // Row r only ever sees its own field of the captured vector.
  for (genvar r = 1; r < row; r++) begin : g_skew
    mac_row_skew #(
      .bw   (bw),
      .depth(r)
    ) u_skew (
      .clk     (clk),
      .reset   (reset),
      .in_data (slot_data_q[r*bw +: bw]),
      .in_inst (slot_inst_q),
      .out_data(out_w[r*bw +: bw]),
      .out_inst(inst_w[r*2 +: 2])
    );
  end

endmodule
